// File: rtl/csr_pkg.sv
// Shared definitions for the CSR access controller: Zicsr funct3 codes,
// FSM state encoding and the read-only CSR address prefix.
package csr_pkg;

    localparam logic [2:0] CSRRW  = 3'b001;
    localparam logic [2:0] CSRRS  = 3'b010;
    localparam logic [2:0] CSRRC  = 3'b011;
    localparam logic [2:0] CSRRWI = 3'b101;
    localparam logic [2:0] CSRRSI = 3'b110;
    localparam logic [2:0] CSRRCI = 3'b111;

    // addr[11:10] == 2'b11 marks a read-only CSR
    localparam logic [1:0] RO_PREFIX = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    function automatic logic is_read_only(input logic [1:0] prefix);
        return (prefix == RO_PREFIX);
    endfunction

endpackage

// File: rtl/csr_access_ctrl_if.sv
// Request, CSR-file and response signals of the CSR access controller.
// master = pipeline plus CSR file side, slave = the controller itself.
interface csr_access_ctrl_if #(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_funct3;
    logic [CSR_AW-1:0] req_csr_addr;
    logic [4:0]        req_rs1;
    logic [XLEN-1:0]   req_rs1_data;
    logic [4:0]        req_rd;
    logic              flush;
    logic [CSR_AW-1:0] csr_addr;
    logic [XLEN-1:0]   csr_din;
    logic              wrt_en;
    logic [XLEN-1:0]   csr_dout;
    logic              resp_valid;
    logic [4:0]        resp_rd;
    logic              resp_rd_we;
    logic [XLEN-1:0]   resp_data;
    logic              resp_illegal;

    modport master (
        output req_valid, req_funct3, req_csr_addr, req_rs1, req_rs1_data, req_rd,
        output flush, csr_dout,
        input  req_ready, csr_addr, csr_din, wrt_en,
        input  resp_valid, resp_rd, resp_rd_we, resp_data, resp_illegal
    );

    modport slave (
        input  req_valid, req_funct3, req_csr_addr, req_rs1, req_rs1_data, req_rd,
        input  flush, csr_dout,
        output req_ready, csr_addr, csr_din, wrt_en,
        output resp_valid, resp_rd, resp_rd_we, resp_data, resp_illegal
    );

endinterface

// File: rtl/csr_alu.sv
// Combinational new-value, write-qualify and illegal-access computation
// for a single Zicsr instruction.
module csr_alu
    import csr_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [4:0]      rs1,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [1:0]      addr_prefix,
    input  logic [XLEN-1:0] old_val,
    output logic [XLEN-1:0] new_val,
    output logic            do_write,
    output logic            illegal
);

    logic [XLEN-1:0] src_s;

    // Operand select, operation and legality check
    always_comb begin
        src_s    = funct3[2] ? {{(XLEN-5){1'b0}}, rs1} : rs1_data;
        new_val  = old_val;
        do_write = 1'b0;
        case (funct3)
            CSRRW, CSRRWI: begin
                new_val  = src_s;
                do_write = 1'b1;
            end
            // set/clear forms skip the write on an x0/zero-immediate field, not on a zero value
            CSRRS, CSRRSI: begin
                new_val  = old_val | src_s;
                do_write = (rs1 != 5'd0);
            end
            CSRRC, CSRRCI: begin
                new_val  = old_val & ~src_s;
                do_write = (rs1 != 5'd0);
            end
            default: begin
                new_val  = old_val;
                do_write = 1'b0;
            end
        endcase
        illegal = (funct3[1:0] == 2'b00) || (do_write && is_read_only(addr_prefix));
    end

endmodule

// File: rtl/csr_access_ctrl.sv
// EX-stage CSR read-modify-write sequencer: IDLE -> READ -> WRITE, returning
// the old CSR value and an illegal flag on a one-cycle response pulse.
module csr_access_ctrl
    import csr_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int CSR_AW = 12
) (
    input  logic            clk,
    input  logic            reset,
    csr_access_ctrl_if.slave bus
);

    state_t            state_r;
    state_t            state_next_s;
    logic [2:0]        funct3_r;
    logic [CSR_AW-1:0] addr_r;
    logic [4:0]        rs1_r;
    logic [XLEN-1:0]   rs1_data_r;
    logic [4:0]        rd_r;
    logic [XLEN-1:0]   old_r;
    logic              accept_s;
    logic [XLEN-1:0]   new_val_s;
    logic              do_write_s;
    logic              illegal_s;

    assign bus.req_ready = (state_r == IDLE) && !reset;
    assign accept_s      = bus.req_valid && bus.req_ready && !bus.flush;

    csr_alu #(.XLEN(XLEN)) u_alu (
        .funct3      (funct3_r),
        .rs1         (rs1_r),
        .rs1_data    (rs1_data_r),
        .addr_prefix (addr_r[CSR_AW-1 -: 2]),
        .old_val     (old_r),
        .new_val     (new_val_s),
        .do_write    (do_write_s),
        .illegal     (illegal_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; flush returns to IDLE from anywhere
    always_comb begin
        state_next_s = state_r;
        if (bus.flush) begin
            state_next_s = IDLE;
        end else begin
            case (state_r)
                IDLE:    state_next_s = accept_s ? READ : IDLE;
                READ:    state_next_s = WRITE;
                WRITE:   state_next_s = IDLE;
                default: state_next_s = IDLE;
            endcase
        end
    end

    // Request latches, loaded on the accept edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            funct3_r   <= 3'd0;
            addr_r     <= '0;
            rs1_r      <= 5'd0;
            rs1_data_r <= '0;
            rd_r       <= 5'd0;
        end else if (accept_s) begin
            funct3_r   <= bus.req_funct3;
            addr_r     <= bus.req_csr_addr;
            rs1_r      <= bus.req_rs1;
            rs1_data_r <= bus.req_rs1_data;
            rd_r       <= bus.req_rd;
        end
    end

    // Old CSR value captured at the end of the READ cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            old_r <= '0;
        end else if (state_r == READ) begin
            old_r <= bus.csr_dout;
        end
    end

    // CSR-file and response outputs; strobes only live in WRITE and flush kills them at once
    always_comb begin
        bus.csr_addr     = addr_r;
        bus.csr_din      = new_val_s;
        bus.resp_data    = old_r;
        bus.resp_rd      = rd_r;
        bus.wrt_en       = 1'b0;
        bus.resp_valid   = 1'b0;
        bus.resp_rd_we   = 1'b0;
        bus.resp_illegal = 1'b0;
        if (state_r == WRITE) begin
            bus.wrt_en       = do_write_s && !illegal_s && !bus.flush;
            bus.resp_valid   = !bus.flush;
            bus.resp_rd_we   = (rd_r != 5'd0) && !illegal_s;
            bus.resp_illegal = illegal_s;
        end else begin
            bus.wrt_en       = 1'b0;
            bus.resp_valid   = 1'b0;
        end
    end

endmodule

// File: tb/tb_csr_access_ctrl.sv
// Directed bench for csr_access_ctrl with a behavioural CSR file model.
module tb_csr_access_ctrl;
    import csr_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    csr_access_ctrl_if bus ();

    csr_access_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    logic [31:0] mem [0:4095];
    logic        pre_en;
    logic [11:0] pre_addr;
    logic [31:0] pre_val;
    int          n_checks = 0;
    int          n_fail   = 0;

    assign bus.csr_dout = mem[bus.csr_addr];

    // CSR file: bench preload or DUT write
    always @(posedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_val;
        else if (bus.wrt_en) mem[bus.csr_addr] <= bus.csr_din;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        pre_addr = a;
        pre_val  = v;
        pre_en   = 1'b1;
        @(posedge clk);
        #1 pre_en = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the response
    task automatic run_req(input string tag, input logic [2:0] f3, input logic [11:0] a,
                           input logic [4:0] rs1, input logic [31:0] d, input logic [4:0] rd,
                           input logic exp_wr, input logic [31:0] exp_din,
                           input logic [31:0] exp_data, input logic exp_we, input logic exp_ill);
        bus.req_valid    = 1'b1;
        bus.req_funct3   = f3;
        bus.req_csr_addr = a;
        bus.req_rs1      = rs1;
        bus.req_rs1_data = d;
        bus.req_rd       = rd;
        #1 check({tag, ".ready_idle"}, {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        bus.req_valid = 1'b0;
        check({tag, ".ready_read"}, {31'd0, bus.req_ready}, 32'd0);
        check({tag, ".wen_read"}, {31'd0, bus.wrt_en}, 32'd0);
        check({tag, ".vld_read"}, {31'd0, bus.resp_valid}, 32'd0);
        check({tag, ".addr_read"}, {20'd0, bus.csr_addr}, {20'd0, a});
        @(negedge clk);
        check({tag, ".ready_wr"}, {31'd0, bus.req_ready}, 32'd0);
        check({tag, ".wen"}, {31'd0, bus.wrt_en}, {31'd0, exp_wr});
        if (exp_wr) check({tag, ".din"}, bus.csr_din, exp_din);
        check({tag, ".vld"}, {31'd0, bus.resp_valid}, 32'd1);
        check({tag, ".data"}, bus.resp_data, exp_data);
        check({tag, ".rd"}, {27'd0, bus.resp_rd}, {27'd0, rd});
        check({tag, ".rd_we"}, {31'd0, bus.resp_rd_we}, {31'd0, exp_we});
        check({tag, ".ill"}, {31'd0, bus.resp_illegal}, {31'd0, exp_ill});
        @(negedge clk);
        check({tag, ".ready_after"}, {31'd0, bus.req_ready}, 32'd1);
        check({tag, ".vld_after"}, {31'd0, bus.resp_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        pre_en = 1'b0; pre_addr = 12'd0; pre_val = 32'd0;
        bus.req_valid = 1'b0; bus.req_funct3 = 3'd0; bus.req_csr_addr = 12'd0;
        bus.req_rs1 = 5'd0; bus.req_rs1_data = 32'd0; bus.req_rd = 5'd0; bus.flush = 1'b0;
        mem[12'h000] = 32'd0;

        @(negedge clk);
        check("rst.ready", {31'd0, bus.req_ready}, 32'd0);
        check("rst.wen", {31'd0, bus.wrt_en}, 32'd0);
        check("rst.vld", {31'd0, bus.resp_valid}, 32'd0);
        check("rst.addr", {20'd0, bus.csr_addr}, 32'd0);
        check("rst.data", bus.resp_data, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("rst.ready_rel", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        // CSRRW
        preload(12'h340, 32'h12345678);
        run_req("rw", CSRRW, 12'h340, 5'd7, 32'hDEADBEEF, 5'd5, 1'b1, 32'hDEADBEEF, 32'h12345678, 1'b1, 1'b0);
        check("rw.mem", mem[12'h340], 32'hDEADBEEF);

        // CSRRS x0 reads only, then CSRRCI zimm=8
        preload(12'h300, 32'h00000088);
        run_req("rs_x0", CSRRS, 12'h300, 5'd0, 32'h0000FFFF, 5'd3, 1'b0, 32'd0, 32'h00000088, 1'b1, 1'b0);
        check("rs_x0.mem", mem[12'h300], 32'h00000088);
        run_req("rci", CSRRCI, 12'h300, 5'h08, 32'hFFFFFFFF, 5'd4, 1'b1, 32'h00000080, 32'h00000088, 1'b1, 1'b0);
        check("rci.mem", mem[12'h300], 32'h00000080);

        // CSRRSI zimm=0x1F, rd=x0
        preload(12'h300, 32'h00000100);
        run_req("rsi", CSRRSI, 12'h300, 5'h1F, 32'h0, 5'd0, 1'b1, 32'h0000011F, 32'h00000100, 1'b0, 1'b0);
        check("rsi.mem", mem[12'h300], 32'h0000011F);

        // read-only CSR and reserved funct3
        preload(12'hC00, 32'hABCD0001);
        run_req("ro_rw", CSRRW, 12'hC00, 5'd7, 32'h00001234, 5'd3, 1'b0, 32'd0, 32'hABCD0001, 1'b0, 1'b1);
        check("ro_rw.mem", mem[12'hC00], 32'hABCD0001);
        run_req("ro_rs0", CSRRS, 12'hC00, 5'd0, 32'h00001234, 5'd6, 1'b0, 32'd0, 32'hABCD0001, 1'b1, 1'b0);
        run_req("f100", 3'b100, 12'h340, 5'd4, 32'h0000FFFF, 5'd2, 1'b0, 32'd0, 32'hDEADBEEF, 1'b0, 1'b1);
        check("f100.mem", mem[12'h340], 32'hDEADBEEF);

        // flush during WRITE
        bus.req_valid = 1'b1; bus.req_funct3 = CSRRW; bus.req_csr_addr = 12'h340;
        bus.req_rs1 = 5'd1; bus.req_rs1_data = 32'h00000055; bus.req_rd = 5'd5;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        bus.flush = 1'b1;
        #1 check("flw.wen", {31'd0, bus.wrt_en}, 32'd0);
        check("flw.vld", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1 check("flw.ready", {31'd0, bus.req_ready}, 32'd1);
        check("flw.mem", mem[12'h340], 32'hDEADBEEF);

        // flush during READ, with req_valid held high under flush
        @(negedge clk);
        bus.req_valid = 1'b1;
        @(negedge clk);
        bus.flush = 1'b1;
        @(negedge clk);
        check("flr.vld", {31'd0, bus.resp_valid}, 32'd0);
        check("flr.ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        check("fli.ignored", {31'd0, bus.req_ready}, 32'd1);
        bus.flush = 1'b0; bus.req_valid = 1'b0;
        @(negedge clk);
        check("flr.mem", mem[12'h340], 32'hDEADBEEF);

        // asynchronous reset mid-READ
        bus.req_valid = 1'b1; bus.req_funct3 = CSRRW; bus.req_csr_addr = 12'h340;
        bus.req_rs1 = 5'd1; bus.req_rs1_data = 32'hCAFEF00D; bus.req_rd = 5'd9;
        @(negedge clk);
        bus.req_valid = 1'b0;
        check("ares.addr_pre", {20'd0, bus.csr_addr}, 32'h00000340);
        reset = 1'b1;
        #1 check("ares.ready", {31'd0, bus.req_ready}, 32'd0);
        check("ares.addr", {20'd0, bus.csr_addr}, 32'd0);
        check("ares.din", bus.csr_din, 32'd0);
        check("ares.rd", {27'd0, bus.resp_rd}, 32'd0);
        check("ares.wen", {31'd0, bus.wrt_en}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1 check("ares.ready_rel", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        check("ares.vld", {31'd0, bus.resp_valid}, 32'd0);
        check("ares.mem", mem[12'h340], 32'hDEADBEEF);

        // back-to-back after reset
        run_req("b2b0", CSRRW, 12'h340, 5'd3, 32'h0000A5A5, 5'd1, 1'b1, 32'h0000A5A5, 32'hDEADBEEF, 1'b1, 1'b0);
        run_req("b2b1", CSRRC, 12'h340, 5'd2, 32'h0000000F, 5'd8, 1'b1, 32'h0000A5A0, 32'h0000A5A5, 1'b1, 1'b0);
        check("b2b.mem", mem[12'h340], 32'h0000A5A0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
